gba_bw_pixel_streamer: RTL and testbench

- Sits directly downstream of the GBA B/W intro image block RAMs.
- Walks the 1-bit-per-pixel image byte by byte over the RAM read port (rd_en/rd_addr → data_out/valid_out).
- Expands each bit, MSB first, into one 16-bit RGB565 pixel and hands pixels to the SPI LCD writer over a valid/ready handshake.
- One start pulse streams exactly one full frame.

---
 rtl/gba_bw_pixel_streamer.sv | 196 +++++++++++++++++++
 tb/tb_gba_bw_pixel_streamer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gba_bw_pixel_streamer.sv
// ----------------------------------------------------------------------------
// gba_bw_pixel_streamer
//
// Purpose:
//   Reads the 1-bit-per-pixel GBA B/W intro image out of its block RAMs one
//   byte at a time. Each bit is expanded, MSB first, into one 16-bit RGB565
//   pixel. Pixels go to the SPI LCD writer over a valid/ready handshake.
//   A single start pulse streams exactly one full frame of NUM_BYTES bytes.
//
// Parameters:
//   NUM_BYTES  image bytes per frame (legal range 1..2**ADDR_W)
//   ADDR_W     byte address width. The RAM side decodes the upper bits as
//              the bank select and the lower 9 bits as the in-bank address.
//   FG_COLOR   RGB565 value for an image bit of 1
//   BG_COLOR   RGB565 value for an image bit of 0
//
// Optional feature:
//   GBA_BW_INVERT_EN  when defined, the colour mapping is swapped so that the
//                     frame comes out as a negative image. Handshake, timing
//                     and addressing do not change.
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle frame request, honoured only when idle
//   o_busy       high from the cycle after an accepted start through DONE
//   o_done       one-cycle pulse after the last pixel handshake
//   o_rd_en      RAM read strobe (one cycle per byte)
//   o_rd_addr    RAM byte address
//   i_rd_data    RAM read data
//   i_rd_valid   RAM read data valid
//   o_pix_data   RGB565 pixel
//   o_pix_valid  pixel available
//   i_pix_ready  downstream accepts the pixel
//   o_pix_last   marks the final pixel of the frame
// ----------------------------------------------------------------------------
module gba_bw_pixel_streamer #(
    parameter int          NUM_BYTES = 1600,
    parameter int          ADDR_W    = 11,
    parameter logic [15:0] FG_COLOR  = 16'hFFFF,
    parameter logic [15:0] BG_COLOR  = 16'h0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    input  logic              i_rd_valid,
    output logic [15:0]       o_pix_data,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,
    output logic              o_pix_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(NUM_BYTES - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_byte_cnt;
    logic [2:0]          r_bit_cnt;
    // The bit currently on the bus is already registered in r_pix_data.
    // Only the seven bits still to be shown are kept here, and the next
    // bit to show always sits at bit 6.
    logic [6:0]          r_shreg;

    logic                r_busy;
    logic                r_done;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [15:0]         r_pix_data;
    logic                r_pix_valid;
    logic                r_pix_last;

    logic                w_last_byte;

    // Maps one image bit to its RGB565 colour. The negative-image build
    // only swaps the two colours.
    function automatic logic [15:0] f_color(input logic b);
`ifdef GBA_BW_INVERT_EN
        return b ? BG_COLOR : FG_COLOR;
`else
        return b ? FG_COLOR : BG_COLOR;
`endif
    endfunction

    assign w_last_byte = (r_byte_cnt == LAST_BYTE);

    // Single FSM that walks the frame. Every output is registered here, so
    // neither i_pix_ready nor i_rd_valid reaches an output combinationally.
    // Each output value is set on the transition into the state where it
    // must be visible. r_pix_valid is high exactly while in SHIFT, so the
    // handshake is simply i_pix_ready sampled in SHIFT. Without a handshake
    // nothing in SHIFT changes, which keeps the pixel steady under
    // backpressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_byte_cnt <= '0;
                        r_rd_addr  <= '0;
                        r_rd_en    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (i_rd_valid) begin
                        r_shreg     <= i_rd_data[6:0];
                        r_bit_cnt   <= 3'd0;
                        r_pix_data  <= f_color(i_rd_data[7]);
                        r_pix_valid <= 1'b1;
                        r_pix_last  <= 1'b0;
                        r_state     <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (i_pix_ready) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_pix_valid <= 1'b0;
                            r_pix_last  <= 1'b0;
                            if (w_last_byte) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                                r_rd_addr  <= r_byte_cnt + 1'b1;
                                r_rd_en    <= 1'b1;
                                r_state    <= S_FETCH;
                            end
                        end else begin
                            r_shreg    <= {r_shreg[5:0], 1'b0};
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            r_pix_data <= f_color(r_shreg[6]);
                            // The pixel being loaded is bit 7 when the count
                            // currently reads 6.
                            r_pix_last <= (r_bit_cnt == 3'd6) && w_last_byte;
                        end
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy      <= 1'b0;
                    r_pix_valid <= 1'b0;
                    r_pix_last  <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr   = r_rd_addr;
    assign o_pix_data  = r_pix_data;
    assign o_pix_valid = r_pix_valid;
    assign o_pix_last  = r_pix_last;

endmodule

// File: tb/tb_gba_bw_pixel_streamer.sv
// ----------------------------------------------------------------------------
// tb_gba_bw_pixel_streamer
//
// Drives gba_bw_pixel_streamer with a small behavioural RAM whose read
// latency can be changed. The expected pixel stream is computed directly
// from the RAM image contents and the colour rule. Stimulus includes
// directed and random frames, random backpressure, ignored start pulses,
// and an asynchronous mid-frame reset.
// ----------------------------------------------------------------------------
module tb_gba_bw_pixel_streamer;

   localparam int          NB = 4;
   localparam int          AW = 11;
   localparam logic [15:0] FG = 16'hFFFF;
   localparam logic [15:0] BG = 16'h0000;

   logic          clk = 1'b0;
   logic          rstN;
   logic          iStart;
   logic          oBusy;
   logic          oDone;
   logic          oRdEn;
   logic [AW-1:0] oRdAddr;
   logic [7:0]    iRdData;
   logic          iRdValid;
   logic [15:0]   oPixData;
   logic          oPixValid;
   logic          iPixReady;
   logic          oPixLast;

   always #5 clk = ~clk;

   gba_bw_pixel_streamer #(
      .NUM_BYTES (NB),
      .ADDR_W    (AW),
      .FG_COLOR  (FG),
      .BG_COLOR  (BG)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_start     (iStart),
      .o_busy      (oBusy),
      .o_done      (oDone),
      .o_rd_en     (oRdEn),
      .o_rd_addr   (oRdAddr),
      .i_rd_data   (iRdData),
      .i_rd_valid  (iRdValid),
      .o_pix_data  (oPixData),
      .o_pix_valid (oPixValid),
      .i_pix_ready (iPixReady),
      .o_pix_last  (oPixLast)
   );

   int checksRun    = 0;
   int checksPassed = 0;

   // Counts every comparison and reports any mismatch on a single line.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checksRun++;
      if (obs === exp) checksPassed++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Image contents and the pixel this image should produce at a given
   // position in the frame.
   logic [7:0] ram [NB];

   function automatic logic [15:0] expPixel(input int idx);
      int b;
      b = (int'(ram[idx / 8]) >> (7 - (idx % 8))) & 1;
`ifdef GBA_BW_INVERT_EN
      return (b == 1) ? BG : FG;
`else
      return (b == 1) ? FG : BG;
`endif
   endfunction

   // Behavioural RAM. A read strobe returns the addressed byte after ramLat
   // cycles. Between reads the data bus carries random junk.
   int ramLat   = 1;
   int ramCnt;
   int ramAddrQ;

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ramCnt   <= 0;
         ramAddrQ <= 0;
         iRdValid <= 1'b0;
         iRdData  <= 8'h00;
      end else begin
         iRdValid <= 1'b0;
         iRdData  <= 8'($urandom);
         if (oRdEn) begin
            ramAddrQ <= int'(oRdAddr) % NB;
            if (ramLat == 1) begin
               iRdValid <= 1'b1;
               iRdData  <= ram[int'(oRdAddr) % NB];
            end else begin
               ramCnt <= ramLat - 1;
            end
         end else if (ramCnt != 0) begin
            ramCnt <= ramCnt - 1;
            if (ramCnt == 1) begin
               iRdValid <= 1'b1;
               iRdData  <= ram[ramAddrQ];
            end
         end
      end
   end

   int cycleCnt = 0;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Scoreboard state shared between the monitor and the sequencer.
   int          pixIdx;
   int          fetchIdx;
   int          doneCount;
   int          fetchCycle;
   bit          firstSeen;
   bit          prevStall;
   logic [15:0] prevData;
   logic        prevLast;
   bit          timedMode;
   bit          readyRandom;
   bit          injectDoneStart;
   bit          doneStartPulse;

   // Monitor on the falling edge. It chooses pix_ready for the coming
   // rising edge, scores every handshake, checks that outputs stay stable
   // under backpressure, and checks read addresses and the done pulse.
   initial begin
      forever begin
         @(negedge clk);
         if (!rstN) begin
            prevStall      = 1'b0;
            doneStartPulse = 1'b0;
         end else begin
            if (doneStartPulse) begin
               iStart         = 1'b0;
               doneStartPulse = 1'b0;
            end
            iPixReady = readyRandom ? ($urandom_range(0, 2) != 0) : 1'b1;

            if (oRdEn) begin
               checkOutput("rd_addr", 32'(oRdAddr), 32'(fetchIdx));
               if (fetchIdx == 0) fetchCycle = cycleCnt;
               fetchIdx++;
            end

            if (oPixValid) begin
               if (!firstSeen) begin
                  firstSeen = 1'b1;
                  if (timedMode) checkOutput("first_valid_latency", 32'(cycleCnt - fetchCycle), 32'd2);
               end
               if (prevStall) begin
                  checkOutput("stall_data", 32'(oPixData), 32'(prevData));
                  checkOutput("stall_last", 32'(oPixLast), 32'(prevLast));
               end
               if (iPixReady) begin
                  if (pixIdx >= 8 * NB) begin
                     checkOutput("extra_pixel", 32'(pixIdx), 32'(8 * NB - 1));
                  end else begin
                     checkOutput("pix_data", 32'(oPixData), 32'(expPixel(pixIdx)));
                     checkOutput("pix_last", 32'(oPixLast), 32'(pixIdx == 8 * NB - 1));
                  end
                  pixIdx++;
               end
            end
            prevStall = oPixValid && !iPixReady;
            prevData  = oPixData;
            prevLast  = oPixLast;

            if (oDone) begin
               doneCount++;
               if (timedMode) checkOutput("done_timing", 32'(cycleCnt - fetchCycle), 32'(10 * NB));
               if (injectDoneStart) begin
                  iStart         = 1'b1;
                  doneStartPulse = 1'b1;
               end
            end
         end
      end
   end

   task automatic prepFrame(input bit randomData, input int lat, input bit rdyRand, input bit doneStart);
      ramLat          = lat;
      readyRandom     = rdyRand;
      timedMode       = (lat == 1) && !rdyRand;
      injectDoneStart = doneStart;
      if (randomData) begin
         for (int i = 0; i < NB; i++) ram[i] = 8'($urandom);
      end
      pixIdx    = 0;
      fetchIdx  = 0;
      doneCount = 0;
      firstSeen = 1'b0;
   endtask

   // Runs one frame from a single start pulse. It can also pulse start
   // mid-frame and/or during the DONE cycle, then checks the frame totals.
   task automatic applyStimulus(input bit randomData, input int lat, input bit rdyRand,
                                input bit midStart, input bit doneStart);
      prepFrame(randomData, lat, rdyRand, doneStart);
      @(negedge clk);
      iStart = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
      checkOutput("busy_after_start", 32'(oBusy), 32'd1);
      if (midStart) begin
         for (int c = 0; c < 2000 && pixIdx < 5; c++) @(negedge clk);
         iStart = 1'b1;
         @(negedge clk);
         iStart = 1'b0;
      end
      for (int c = 0; c < 4000 && doneCount == 0; c++) @(negedge clk);
      repeat (6) @(negedge clk);
      checkOutput("done_count", 32'(doneCount), 32'd1);
      checkOutput("pixel_count", 32'(pixIdx), 32'(8 * NB));
      checkOutput("fetch_count", 32'(fetchIdx), 32'(NB));
      checkOutput("idle_busy", 32'(oBusy), 32'd0);
      injectDoneStart = 1'b0;
   endtask

   initial begin
      rstN        = 1'b0;
      iStart      = 1'b0;
      iPixReady   = 1'b0;
      readyRandom = 1'b0;

      // Reset held with random inputs: every output sits at its reset value.
      repeat (5) begin
         @(negedge clk);
         iStart    = 1'($urandom);
         iPixReady = 1'($urandom);
      end
      @(negedge clk);
      checkOutput("rst_busy", 32'(oBusy), 32'd0);
      checkOutput("rst_done", 32'(oDone), 32'd0);
      checkOutput("rst_rd_en", 32'(oRdEn), 32'd0);
      checkOutput("rst_rd_addr", 32'(oRdAddr), 32'd0);
      checkOutput("rst_pix_data", 32'(oPixData), 32'd0);
      checkOutput("rst_pix_valid", 32'(oPixValid), 32'd0);
      checkOutput("rst_pix_last", 32'(oPixLast), 32'd0);
      iStart = 1'b0;
      rstN   = 1'b1;
      repeat (2) @(negedge clk);

      // Directed image, 1-cycle RAM, ready held high: latency and frame timing.
      ram[0] = 8'hE0;
      ram[1] = 8'h7F;
      ram[2] = 8'hA5;
      ram[3] = 8'h01;
      applyStimulus(1'b0, 1, 1'b0, 1'b0, 1'b0);

      // Backpressure with a slow RAM, plus start pulses mid-frame and in DONE.
      applyStimulus(1'b1, 3, 1'b1, 1'b1, 1'b1);

      // Random images with random latency and random ready.
      for (int f = 0; f < 3; f++) begin
         applyStimulus(1'b1, int'($urandom_range(1, 4)), 1'b1, 1'b0, 1'b0);
      end

      // Asynchronous reset while the third byte is being streamed.
      prepFrame(1'b1, 2, 1'b1, 1'b0);
      @(negedge clk);
      iStart = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
      for (int c = 0; c < 2000 && !(pixIdx >= 17 && pixIdx < 24 && oPixValid); c++) @(negedge clk);
      checkOutput("pre_reset_valid", 32'(oPixValid), 32'd1);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("async_pix_valid", 32'(oPixValid), 32'd0);
      checkOutput("async_busy", 32'(oBusy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      // A fresh start after the reset must fetch from address 0 and stream
      // the whole frame.
      applyStimulus(1'b1, 1, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d/%0d checks passed", checksPassed, checksRun);
      $finish;
   end

endmodule
